pc_sel_ctrl: RTL and testbench
==============================

# pc_sel_ctrl

Parametrised PC-select controller between the instruction decoder and the PC mux feeding instruction memory. It arbitrates several prioritised redirect sources (exception, branch, jump, …) against the decoder's default select. It holds a redirect until instruction memory accepts it, then drives a fixed-length flush window for the fetch stage. A saturating redirect counter is provided for performance monitoring.

## Interface
Parameters:
- SEL_W, 2, width of a PC-mux select code
- NSRC, 3, number of redirect sources; index 0 is highest priority
- FLUSH_CYC, 2, flush-window length in cycles after an accepted redirect (0 = no flush)
- CNT_W, 16, redirect counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec_sel  in  SEL_W  decoder's default PC-mux select
- redir_req  in  NSRC  per-source redirect request; held high until acked
- redir_sel  in  NSRC*SEL_W  packed per-source select code; source i occupies bits [i*SEL_W +: SEL_W]
- imem_ready  in  1  instruction memory accepts the current fetch select this cycle
- pc_sel  out  SEL_W  select code to the PC mux
- redir_ack  out  NSRC  one-hot; pulses in the cycle a source's redirect is accepted
- flush  out  1  fetch-stage flush window active
- busy  out  1  state is not IDLE
- redir_count  out  CNT_W  accepted redirects, saturating

## Operation
- States: IDLE, PEND, FLUSH.
- Registers:
  - st
  - pend_idx (source index)
  - pend_sel (SEL_W)
  - fcnt (wide enough to hold FLUSH_CYC)
  - redir_count
- Arbitration: the winner is the lowest-index set bit of redir_req.
- IDLE, no request:
  - pc_sel = dec_sel
  - redir_ack = 0
- IDLE, request, imem_ready=1:
  - pc_sel = winner's redir_sel; redir_ack[winner] = 1 in the same cycle
  - redir_count increments
  - go to FLUSH with fcnt = FLUSH_CYC; stay in IDLE if FLUSH_CYC = 0
- IDLE, request, imem_ready=0:
  - pc_sel = winner's redir_sel
  - latch winner into pend_idx/pend_sel; go to PEND
- PEND:
  - pc_sel = pend_sel.
  - Preemption: if a source with index lower than pend_idx requests, pc_sel = that source's select this cycle, and it replaces the latch.
  - On imem_ready=1: ack the (possibly preempting) source, increment redir_count, go to FLUSH (or IDLE if FLUSH_CYC = 0).
- FLUSH:
  - flush = 1, pc_sel = dec_sel; fcnt decrements every cycle; leave to IDLE when fcnt reaches 1.
  - Sources 1..NSRC-1 are not acked and wait.
  - redir_req[0] is accepted even during FLUSH: same rules as IDLE; on acceptance fcnt reloads to FLUSH_CYC (window restarts), otherwise go to PEND.
- redir_count saturates at all-ones.
- A request dropped before ack is a protocol violation; behaviour is don't-care, but the block must not hang. If the latched source drops its request while in PEND, the block still acks pend_idx on imem_ready.

## Timing
- Reset (async assert, sync-safe deassert):
  - st = IDLE
  - pend_idx = 0, pend_sel = 0, fcnt = 0, redir_count = 0
  - flush = 0, busy = 0, redir_ack = 0, pc_sel = dec_sel
- pc_sel and redir_ack are combinational from state and inputs; there is zero added latency from request to select.
- flush and busy are decoded from registered state.
- flush rises the cycle after acceptance and stays high for exactly FLUSH_CYC cycles.
- redir_count updates at the clock edge ending the acceptance cycle.
- Reset mid-PEND or mid-FLUSH: the pending redirect is discarded, no ack is issued, and the count is cleared.
- Simultaneous requests from all sources: only source 0 is acked. Others are served one per acceptance, in priority order, after each flush window.

## Test plan
- Reset with dec_sel=1 and no requests -> pc_sel=1, flush=0, busy=0, redir_count=0; pc_sel follows dec_sel changes 0→3 combinationally.
- redir_req=3'b010, redir_sel[3:2]=2, imem_ready=1 -> pc_sel=2 and redir_ack=3'b010 the same cycle; flush=1 for the next 2 cycles; redir_count=1.
- redir_req=3'b100, redir_sel[5:4]=3, imem_ready=0 for 3 cycles then 1 -> busy=1, pc_sel=3 throughout, ack[2] only in the ready cycle; then a 2-cycle flush.
- In PEND holding source 2, assert redir_req[0] with redir_sel[1:0]=1 -> pc_sel=1 immediately; on ready, ack=3'b001 and the latch is replaced; source 2 is served after the flush.
- During FLUSH, redir_req=3'b011 with imem_ready=1 -> ack=3'b001, fcnt reloads so flush lasts 2 more cycles; source 1 is acked only after flush ends.
- Drive CNT_W=4 and 17 accepted redirects -> redir_count=15 and holds; asserting rst_n=0 mid-FLUSH -> flush=0, count=0 asynchronously.

Source files
------------

// File: rtl/pc_sel_ctrl.sv
// pc_sel_ctrl: PC-select controller between the decoder and the PC mux.
// Arbitrates prioritised redirect sources against the decoder's default
// select, holds a redirect until instruction memory accepts it, then opens
// a fixed-length fetch flush window. Counts accepted redirects (saturating).
module pc_sel_ctrl #(
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned NSRC      = 3,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEL_W-1:0]        dec_sel,
    input  logic [NSRC-1:0]         redir_req,
    input  logic [NSRC*SEL_W-1:0]   redir_sel,
    input  logic                    imem_ready,
    output logic [SEL_W-1:0]        pc_sel,
    output logic [NSRC-1:0]         redir_ack,
    output logic                    flush,
    output logic                    busy,
    output logic [CNT_W-1:0]        redir_count
);

    localparam int unsigned IDX_W  = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned FCNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC);
    localparam bit HAS_FLUSH = (FLUSH_CYC != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e             st_q, st_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   redir_count_q;

    logic [SEL_W-1:0]   src_sel [NSRC];
    logic               req_any;
    logic [IDX_W-1:0]   win_idx;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [SEL_W-1:0]   sel_code;
    logic               accept;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign src_sel[g] = redir_sel[g*SEL_W +: SEL_W];
    end

    // Priority pick: lowest-index active request wins.
    always_comb begin
        req_any = |redir_req;
        win_idx = '0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (redir_req[i-1]) begin
                win_idx = IDX_W'(i - 1);
            end
        end
    end

    // Next-state, select and acknowledge decode.
    // A single "selected source" (sel_idx/sel_code) is resolved per state,
    // then shared accept/latch handling applies to IDLE, PEND and FLUSH alike.
    always_comb begin
        st_d       = st_q;
        pend_idx_d = pend_idx_q;
        pend_sel_d = pend_sel_q;
        fcnt_d     = fcnt_q;
        pc_sel     = dec_sel;
        redir_ack  = '0;
        accept     = 1'b0;
        sel_vld    = 1'b0;
        sel_idx    = win_idx;
        sel_code   = src_sel[win_idx];

        unique case (st_q)
            ST_IDLE: begin
                sel_vld = req_any;
            end
            ST_PEND: begin
                sel_vld = 1'b1;
                if (!(req_any && (win_idx < pend_idx_q))) begin
                    sel_idx  = pend_idx_q;
                    sel_code = pend_sel_q;
                end
            end
            ST_FLUSH: begin
                sel_vld  = redir_req[0];
                sel_idx  = '0;
                sel_code = src_sel[0];
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

        if (sel_vld) begin
            pc_sel = sel_code;
            if (imem_ready) begin
                redir_ack[sel_idx] = 1'b1;
                accept             = 1'b1;
                if (HAS_FLUSH) begin
                    st_d   = ST_FLUSH;
                    fcnt_d = FCNT_LOAD;
                end else begin
                    st_d = ST_IDLE;
                end
            end else begin
                st_d       = ST_PEND;
                pend_idx_d = sel_idx;
                pend_sel_d = sel_code;
            end
        end else if (st_q == ST_FLUSH) begin
            fcnt_d = fcnt_q - FCNT_W'(1);
            if (fcnt_q <= FCNT_W'(1)) begin
                st_d = ST_IDLE;
            end
        end
    end

    // State, latch and flush-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            pend_idx_q <= '0;
            pend_sel_q <= '0;
            fcnt_q     <= '0;
        end else begin
            st_q       <= st_d;
            pend_idx_q <= pend_idx_d;
            pend_sel_q <= pend_sel_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Saturating count of accepted redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_count_q <= '0;
        end else if (accept && (redir_count_q != '1)) begin
            redir_count_q <= redir_count_q + CNT_W'(1);
        end
    end

    assign flush       = (st_q == ST_FLUSH);
    assign busy        = (st_q != ST_IDLE);
    assign redir_count = redir_count_q;

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// Self-checking bench for pc_sel_ctrl: directed scenarios plus a random
// run compared against a transaction-level reference model.
module tb_pc_sel_ctrl;

    localparam int FLUSH_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  dec_sel = '0;
    logic [2:0]  redir_req = '0;
    logic [5:0]  redir_sel = '0;
    logic        imem_ready = 1'b0;

    logic [1:0]  pc_sel;
    logic [2:0]  redir_ack;
    logic        flush, busy;
    logic [15:0] redir_count;

    logic [1:0]  pc_sel4;
    logic [2:0]  redir_ack4;
    logic        flush4, busy4;
    logic [3:0]  redir_count4;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit         m_pend;
    int         m_pidx;
    logic [1:0] m_psel;
    int         m_fleft;
    int         m_cnt16;
    int         m_cnt4;

    always #5 clk = ~clk;

    pc_sel_ctrl #(.SEL_W(2), .NSRC(3), .FLUSH_CYC(FLUSH_CYC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .dec_sel(dec_sel), .redir_req(redir_req),
        .redir_sel(redir_sel), .imem_ready(imem_ready), .pc_sel(pc_sel),
        .redir_ack(redir_ack), .flush(flush), .busy(busy), .redir_count(redir_count)
    );

    pc_sel_ctrl #(.SEL_W(2), .NSRC(3), .FLUSH_CYC(FLUSH_CYC), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .dec_sel(dec_sel), .redir_req(redir_req),
        .redir_sel(redir_sel), .imem_ready(imem_ready), .pc_sel(pc_sel4),
        .redir_ack(redir_ack4), .flush(flush4), .busy(busy4), .redir_count(redir_count4)
    );

    task automatic do_reset();
        rst_n      = 1'b0;
        redir_req  = '0;
        redir_sel  = '0;
        imem_ready = 1'b0;
        dec_sel    = '0;
        m_pend = 0; m_pidx = 0; m_psel = '0; m_fleft = 0; m_cnt16 = 0; m_cnt4 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0; dec_sel = 2'd1; redir_req = '0; imem_ready = 1'b0;
        #1;
        checks++; if (pc_sel !== 2'd1) begin failures++; $display("FAIL rst_pc_sel got=%0d exp=1", pc_sel); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0b exp=0", flush); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (redir_count !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", redir_count); end
        checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL rst_ack got=%b exp=000", redir_ack); end
        dec_sel = 2'd3;
        #1;
        checks++; if (pc_sel !== 2'd3) begin failures++; $display("FAIL rst_pc_follow3 got=%0d exp=3", pc_sel); end
        dec_sel = 2'd0;
        #1;
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL rst_pc_follow0 got=%0d exp=0", pc_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_rel_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_immediate();
        do_reset();
        dec_sel = 2'd0; redir_sel = 6'b00_10_00; redir_req = 3'b010; imem_ready = 1'b1;
        #1;
        checks++; if (pc_sel !== 2'd2) begin failures++; $display("FAIL imm_pc_sel got=%0d exp=2", pc_sel); end
        checks++; if (redir_ack !== 3'b010) begin failures++; $display("FAIL imm_ack got=%b exp=010", redir_ack); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL imm_flush0 got=%0b exp=0", flush); end
        @(negedge clk);
        redir_req = '0; imem_ready = 1'b0;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL imm_flush1 got=%0b exp=1", flush); end
        checks++; if (redir_count !== 16'd1) begin failures++; $display("FAIL imm_count got=%0d exp=1", redir_count); end
        checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL imm_ack_after got=%b exp=000", redir_ack); end
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL imm_flush2 got=%0b exp=1", flush); end
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL imm_flush_end got=%0b exp=0", flush); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL imm_busy_end got=%0b exp=0", busy); end
    endtask

    task automatic test_pending();
        do_reset();
        dec_sel = 2'd1; redir_sel = 6'b11_00_00; redir_req = 3'b100; imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (pc_sel !== 2'd3) begin failures++; $display("FAIL pend_pc_sel[%0d] got=%0d exp=3", k, pc_sel); end
            checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL pend_ack[%0d] got=%b exp=000", k, redir_ack); end
            checks++; if (busy !== (k != 0)) begin failures++; $display("FAIL pend_busy[%0d] got=%0b exp=%0b", k, busy, (k != 0)); end
            @(negedge clk);
        end
        imem_ready = 1'b1;
        #1;
        checks++; if (pc_sel !== 2'd3) begin failures++; $display("FAIL pend_rdy_pc got=%0d exp=3", pc_sel); end
        checks++; if (redir_ack !== 3'b100) begin failures++; $display("FAIL pend_rdy_ack got=%b exp=100", redir_ack); end
        @(negedge clk);
        redir_req = '0; imem_ready = 1'b0;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL pend_flush1 got=%0b exp=1", flush); end
        checks++; if (pc_sel !== 2'd1) begin failures++; $display("FAIL pend_flush_pc got=%0d exp=1", pc_sel); end
        checks++; if (redir_count !== 16'd1) begin failures++; $display("FAIL pend_count got=%0d exp=1", redir_count); end
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL pend_flush2 got=%0b exp=1", flush); end
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL pend_flush_end got=%0b exp=0", flush); end
    endtask

    task automatic test_preempt();
        do_reset();
        dec_sel = 2'd0; redir_sel = {2'd3, 2'd2, 2'd1}; redir_req = 3'b100; imem_ready = 1'b0;
        #1;
        checks++; if (pc_sel !== 2'd3) begin failures++; $display("FAIL pre_pc_src2 got=%0d exp=3", pc_sel); end
        @(negedge clk);
        redir_req = 3'b101;
        #1;
        checks++; if (pc_sel !== 2'd1) begin failures++; $display("FAIL pre_pc_src0 got=%0d exp=1", pc_sel); end
        checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL pre_ack_wait got=%b exp=000", redir_ack); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_busy got=%0b exp=1", busy); end
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        checks++; if (pc_sel !== 2'd1) begin failures++; $display("FAIL pre_rdy_pc got=%0d exp=1", pc_sel); end
        checks++; if (redir_ack !== 3'b001) begin failures++; $display("FAIL pre_rdy_ack got=%b exp=001", redir_ack); end
        @(negedge clk);
        redir_req = 3'b100;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL pre_fl1 got=%0b exp=1", flush); end
        checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL pre_fl1_ack got=%b exp=000", redir_ack); end
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL pre_fl1_pc got=%0d exp=0", pc_sel); end
        @(negedge clk);
        #1;
        checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL pre_fl2_ack got=%b exp=000", redir_ack); end
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL pre_idle_flush got=%0b exp=0", flush); end
        checks++; if (redir_ack !== 3'b100) begin failures++; $display("FAIL pre_src2_ack got=%b exp=100", redir_ack); end
        checks++; if (pc_sel !== 2'd3) begin failures++; $display("FAIL pre_src2_pc got=%0d exp=3", pc_sel); end
        @(negedge clk);
        redir_req = '0; imem_ready = 1'b0;
        #1;
        checks++; if (redir_count !== 16'd2) begin failures++; $display("FAIL pre_count got=%0d exp=2", redir_count); end
    endtask

    task automatic test_flush_reload();
        do_reset();
        dec_sel = 2'd0; redir_sel = {2'd3, 2'd2, 2'd1}; redir_req = 3'b100; imem_ready = 1'b1;
        #1;
        checks++; if (redir_ack !== 3'b100) begin failures++; $display("FAIL rl_first_ack got=%b exp=100", redir_ack); end
        @(negedge clk);
        redir_req = 3'b011;
        #1;
        checks++; if (redir_ack !== 3'b001) begin failures++; $display("FAIL rl_src0_ack got=%b exp=001", redir_ack); end
        checks++; if (pc_sel !== 2'd1) begin failures++; $display("FAIL rl_src0_pc got=%0d exp=1", pc_sel); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rl_src0_flush got=%0b exp=1", flush); end
        @(negedge clk);
        redir_req = 3'b010;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rl_win1 got=%0b exp=1", flush); end
        checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL rl_win1_ack got=%b exp=000", redir_ack); end
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL rl_win1_pc got=%0d exp=0", pc_sel); end
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rl_win2 got=%0b exp=1", flush); end
        checks++; if (redir_ack !== 3'b000) begin failures++; $display("FAIL rl_win2_ack got=%b exp=000", redir_ack); end
        @(negedge clk);
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rl_end got=%0b exp=0", flush); end
        checks++; if (redir_ack !== 3'b010) begin failures++; $display("FAIL rl_src1_ack got=%b exp=010", redir_ack); end
        checks++; if (pc_sel !== 2'd2) begin failures++; $display("FAIL rl_src1_pc got=%0d exp=2", pc_sel); end
        @(negedge clk);
        redir_req = '0; imem_ready = 1'b0;
        #1;
        checks++; if (redir_count !== 16'd3) begin failures++; $display("FAIL rl_count got=%0d exp=3", redir_count); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        dec_sel = 2'd2; redir_sel = 6'b00_00_11; redir_req = 3'b001; imem_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            checks++; if (redir_ack !== 3'b001) begin failures++; $display("FAIL sat_ack[%0d] got=%b exp=001", i, redir_ack); end
            checks++; if (redir_count4 !== 4'((i > 15) ? 15 : i)) begin
                failures++; $display("FAIL sat_count4[%0d] got=%0d exp=%0d", i, redir_count4, (i > 15) ? 15 : i);
            end
            @(negedge clk);
        end
        redir_req = '0; imem_ready = 1'b0;
        #1;
        checks++; if (redir_count !== 16'd18) begin failures++; $display("FAIL sat_count16 got=%0d exp=18", redir_count); end
        checks++; if (redir_count4 !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", redir_count4); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL sat_flush got=%0b exp=1", flush); end
        rst_n = 1'b0;
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL arst_flush got=%0b exp=0", flush); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        checks++; if (redir_count !== 16'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", redir_count); end
        checks++; if (redir_count4 !== 4'd0) begin failures++; $display("FAIL arst_count4 got=%0d exp=0", redir_count4); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0] drop;
        int         win, cand;
        logic [1:0] esel, exp_pc;
        logic [2:0] exp_ack;
        logic       exp_flush, exp_busy;
        do_reset();
        drop = '0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            redir_req = redir_req & ~drop;
            for (int i = 0; i < 3; i++) begin
                if (!redir_req[i] && ($urandom_range(0, 3) == 0)) begin
                    redir_req[i] = 1'b1;
                    redir_sel[i*2 +: 2] = 2'($urandom_range(0, 3));
                end
            end
            dec_sel    = 2'($urandom_range(0, 3));
            imem_ready = 1'($urandom_range(0, 1));
            #1;
            win = -1;
            for (int i = 2; i >= 0; i--) if (redir_req[i]) win = i;
            cand = -1;
            esel = '0;
            if (m_fleft > 0) begin
                cand = redir_req[0] ? 0 : -1;
                esel = redir_sel[1:0];
            end else if (m_pend) begin
                if (win >= 0 && win < m_pidx) begin
                    cand = win; esel = redir_sel[win*2 +: 2];
                end else begin
                    cand = m_pidx; esel = m_psel;
                end
            end else if (win >= 0) begin
                cand = win; esel = redir_sel[win*2 +: 2];
            end
            exp_pc    = (cand < 0) ? dec_sel : esel;
            exp_ack   = (cand >= 0 && imem_ready) ? 3'(1 << cand) : 3'b000;
            exp_flush = (m_fleft > 0);
            exp_busy  = m_pend || (m_fleft > 0);

            checks++; if (pc_sel !== exp_pc) begin failures++; $display("FAIL rnd_pc_sel n=%0d got=%0d exp=%0d", n, pc_sel, exp_pc); end
            checks++; if (redir_ack !== exp_ack) begin failures++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, redir_ack, exp_ack); end
            checks++; if (flush !== exp_flush) begin failures++; $display("FAIL rnd_flush n=%0d got=%0b exp=%0b", n, flush, exp_flush); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL rnd_busy n=%0d got=%0b exp=%0b", n, busy, exp_busy); end
            checks++; if (redir_count !== 16'(m_cnt16)) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, redir_count, m_cnt16); end
            checks++; if (redir_count4 !== 4'(m_cnt4)) begin failures++; $display("FAIL rnd_count4 n=%0d got=%0d exp=%0d", n, redir_count4, m_cnt4); end
            checks++; if ({pc_sel4, redir_ack4, flush4, busy4} !== {exp_pc, exp_ack, exp_flush, exp_busy}) begin
                failures++; $display("FAIL rnd_c4_outs n=%0d got=%b exp=%b", n, {pc_sel4, redir_ack4, flush4, busy4}, {exp_pc, exp_ack, exp_flush, exp_busy});
            end

            if (cand >= 0 && imem_ready) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
                m_fleft = FLUSH_CYC;
                m_pend  = 0;
            end else if (cand >= 0) begin
                m_pend  = 1;
                m_pidx  = cand;
                m_psel  = esel;
                m_fleft = 0;
            end else if (m_fleft > 0) begin
                m_fleft--;
            end
            drop = exp_ack;
        end
        @(negedge clk);
        redir_req = '0; imem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_pending();
        test_preempt();
        test_flush_reload();
        test_saturate_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
